mem_burst_ctrl: RTL and testbench



---
 rtl/mem_burst_ctrl_pkg.sv | 16 +
 rtl/mem_burst_ctrl_if.sv | 33 +++
 rtl/mem_burst_ctrl_rsp_fifo.sv | 46 ++++
 rtl/mem_burst_ctrl.sv | 126 ++++++++++++
 tb/tb_mem_burst_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_burst_ctrl_pkg.sv
// mem_ctrl_pkg: shared widths, FSM state encoding and the response beat
// layout for the burst controller of the 16x24-bit data memory.
package mem_ctrl_pkg;
  localparam int DATA_W    = 24;  // word width, matches the memory
  localparam int ADDR_W    = 5;   // memory address pins
  localparam int MEM_DEPTH = 16;  // words physically present
  localparam int LEN_W     = 4;   // burst length minus one

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  // One response FIFO entry: read word plus end-of-burst tag.
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } rsp_beat_t;
endpackage

// File: rtl/mem_burst_ctrl_if.sv
// mem_burst_ctrl_if: request port, response port, memory pins and busy flag
// of the burst controller.
//   slave  - controller side (accepts requests, drives memory, sends beats)
//   master - datapath/memory side
interface mem_burst_ctrl_if;
  import mem_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] req_wdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_len, req_wdata, mem_rdata, rsp_ready,
    output req_ready, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_data, rsp_last, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_len, req_wdata, mem_rdata, rsp_ready,
    input  req_ready, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_data, rsp_last, busy
  );
endinterface

// File: rtl/mem_burst_ctrl_rsp_fifo.sv
// rsp_fifo: synchronous FIFO, W bits x DEPTH (power of two).
//   clk, rst     - clock, synchronous active-high reset (flushes pointers)
//   push, din    - write side; a push while full is only taken with a pop
//   pop, dout    - read side; dout is the head entry
//   full, empty, count - occupancy
module rsp_fifo #(
  parameter  int W     = 25,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = store[rp];

  always_ff @(posedge clk)
    if (do_push) store[wp] <= din;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      count <= count + {{(CW-1){1'b0}}, do_push} - {{(CW-1){1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: initiator for the 16x24-bit synchronous data memory.
//   clk, rst      - clock, synchronous active-high reset
//   bus (slave)   - req_* : single-word write / 1..16-word burst read request
//                   mem_* : registered memory pins, mem_rdata one cycle late
//                   rsp_* : read beats with back-pressure, rsp_last on final
//                   busy  : FSM active or beats still queued
// The first read address is issued straight from the accept cycle so the
// first beat is visible three cycles after accept. Each further issue needs
// a free FIFO slot counting reads still in flight, so the FIFO never
// overflows however long rsp_ready stays low.
module mem_burst_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  mem_burst_ctrl_if.slave bus
);
  localparam int MA_W  = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int STAGES = 1;
  typedef logic [CNT_W:0] occ_t;

  state_t           state, state_nxt;
  logic [MA_W-1:0]  rd_addr, rd_addr_nxt;
  logic [LEN_W-1:0] left, left_nxt;   // beats still to issue after beat 0
  logic             accept, issue, issue_last, wr_go, credit;
  logic [MA_W-1:0]  issue_addr;
  // vld_pipe[0]: read address on the pins now; [1]: its data on mem_rdata now
  logic [STAGES:0]  vld_pipe, last_pipe;
  logic [1:0]       outstanding;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty, pop;
  rsp_beat_t        head, beat_in;
  logic             unused_ok;

  assign unused_ok = ^{bus.req_addr[ADDR_W-1:MA_W], fifo_full};

  assign bus.req_ready = (state == IDLE) & ~rst;
  assign accept        = bus.req_valid & bus.req_ready;
  assign outstanding   = {1'b0, vld_pipe[0]} + {1'b0, vld_pipe[1]};
  assign credit        = (occ_t'(fifo_count) + occ_t'(outstanding)) < occ_t'(FIFO_DEPTH);

  always_comb begin
    state_nxt   = state;
    rd_addr_nxt = rd_addr;
    left_nxt    = left;
    issue       = 1'b0;
    issue_last  = 1'b0;
    issue_addr  = rd_addr;
    wr_go       = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (bus.req_we) begin
          wr_go     = 1'b1;
          state_nxt = WRITE;
        end else begin
          // FIFO is empty and nothing in flight in IDLE: beat 0 always has credit
          issue       = 1'b1;
          issue_addr  = bus.req_addr[MA_W-1:0];
          issue_last  = (bus.req_len == '0);
          rd_addr_nxt = bus.req_addr[MA_W-1:0] + 1'b1;
          left_nxt    = bus.req_len;
          state_nxt   = (bus.req_len == '0) ? DRAIN : READ;
        end
      end
      WRITE: state_nxt = IDLE;
      READ: if (credit) begin
        issue       = 1'b1;
        issue_last  = (left == 4'd1);
        rd_addr_nxt = rd_addr + 1'b1;
        left_nxt    = left - 4'd1;
        if (left == 4'd1) state_nxt = DRAIN;
      end
      DRAIN: if (outstanding == 2'd0 && fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rd_addr       <= '0;
      left          <= '0;
      vld_pipe      <= '0;
      last_pipe     <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      state      <= state_nxt;
      rd_addr    <= rd_addr_nxt;
      left       <= left_nxt;
      vld_pipe   <= {vld_pipe[STAGES-1:0], issue};
      last_pipe  <= {last_pipe[STAGES-1:0], issue_last};
      bus.mem_we <= wr_go;
      if (wr_go) begin
        bus.mem_addr  <= ADDR_W'(bus.req_addr[MA_W-1:0]);
        bus.mem_wdata <= bus.req_wdata;
      end else if (issue) begin
        bus.mem_addr  <= ADDR_W'(issue_addr);
      end
    end
  end

  assign beat_in = '{last: last_pipe[STAGES], data: bus.mem_rdata};
  assign pop     = bus.rsp_valid & bus.rsp_ready;

  rsp_fifo #(.W($bits(rsp_beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_pipe[STAGES]),
    .din   (beat_in),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.rsp_valid = ~fifo_empty & ~rst;
  assign bus.rsp_data  = bus.rsp_valid ? head.data : '0;
  assign bus.rsp_last  = bus.rsp_valid & head.last;
  assign bus.busy      = ~rst & ((state != IDLE) | ~fifo_empty);
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Bench for mem_burst_ctrl against a 16x24 synchronous memory model.
// Expected read beats come from a reference memory image and a queue of
// beats per accepted burst; directed checks pin timing and literal data.
module tb_mem_burst_ctrl;
  typedef struct packed {logic [23:0] d; logic l;} beat_t;

  logic clk, rst;
  mem_burst_ctrl_if bus();

  mem_burst_ctrl #(.FIFO_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // data memory: write on we, read data one cycle after the address
  logic [23:0] mem [16];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[3:0]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0, pop_cnt = 0;
  logic [23:0] ref_mem [16];
  logic [23:0] pre_v [16];
  logic [23:0] lit [4];
  logic [3:0]  wrap_a [4];
  beat_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  // every response beat is checked against the model queue
  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else if (bus.rsp_valid) begin
      if (exp_q.size() == 0) chk("spurious_rsp", 32'd1, 32'd0);
      else begin
        chk("rsp_data", bus.rsp_data, exp_q[0].d);
        chk("rsp_last", bus.rsp_last, exp_q[0].l);
        if (bus.rsp_ready) begin
          void'(exp_q.pop_front());
          pop_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_cyc(input int k);
    while (cyc < k) step();
    @(negedge clk);
  endtask

  // call just after a posedge; returns the accept cycle, aligned after the next posedge
  task automatic do_req(input logic we, input logic [4:0] a, input logic [3:0] l,
                        input logic [23:0] d, output int t);
    beat_t b;
    logic [3:0] ad;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a;
    bus.req_len = l; bus.req_wdata = d;
    t = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        t = cyc;
        if (we) ref_mem[a[3:0]] = d;
        else for (int j = 0; j <= int'(l); j++) begin
          ad = a[3:0] + 4'(j);
          b.d = ref_mem[ad];
          b.l = (j == int'(l));
          exp_q.push_back(b);
        end
        break;
      end
    end
    chk("req_accepted", (t >= 0), 32'd1);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int c, output logic [23:0] d, output logic l);
    c = -1; d = '0; l = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        c = cyc; d = bus.rsp_data; l = bus.rsp_last;
        break;
      end
    end
  endtask

  task automatic wait_idle(output int c);
    c = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.req_ready && exp_q.size() == 0) begin
        c = cyc;
        break;
      end
    end
    chk("idle_reached", (c >= 0), 32'd1);
    step();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, c, base;
    logic [23:0] d;
    logic l;
    pre_v[0] = 24'h008000; pre_v[1] = 24'h008000; pre_v[2] = 24'h070000;
    pre_v[3] = 24'h654321; pre_v[4] = 24'h123456; pre_v[5] = 24'h0FEDCB;
    pre_v[6] = 24'h800001; pre_v[7] = 24'h00FFFF; pre_v[8] = 24'h5A5A5A;
    for (int i = 9; i < 16; i++) pre_v[i] = 24'h900000 + 24'(i);
    lit[0] = 24'h008000; lit[1] = 24'h008000; lit[2] = 24'h070000; lit[3] = 24'h654321;
    wrap_a[0] = 4'd14; wrap_a[1] = 4'd15; wrap_a[2] = 4'd0; wrap_a[3] = 4'd1;

    rst = 1'b1; bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_len = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;

    // reset cycle
    step();
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 32'd0);
    chk("rst_mem_we", bus.mem_we, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_rsp_valid", bus.rsp_valid, 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_last", bus.rsp_last, 32'd0);
    chk("rst_busy", bus.busy, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", bus.req_ready, 32'd1);
    step();

    // preload memory through the controller
    for (int i = 0; i < 16; i++) do_req(1'b1, 5'(i), 4'd0, pre_v[i], t);

    // single write then read accepted two cycles later
    do_req(1'b1, 5'd3, 4'd0, 24'hABCDEF, t);
    do_req(1'b0, 5'd3, 4'd0, 24'h0, t2);
    chk("raw_accept_cyc", t2, t + 2);
    wait_rsp(c, d, l);
    chk("raw_first_cyc", c, t2 + 3);
    chk("raw_data", d, 24'hABCDEF);
    chk("raw_last", l, 32'd1);
    wait_idle(c);
    do_req(1'b1, 5'd3, 4'd0, 24'h654321, t);

    // full 16-beat burst without back-pressure
    do_req(1'b0, 5'd0, 4'd15, 24'h0, t);
    for (int n = 0; n < 16; n++) begin
      at_cyc(t + 3 + n);
      chk("burst_valid", bus.rsp_valid, 32'd1);
      chk("burst_last", bus.rsp_last, (n == 15));
      if (n < 4) chk("burst_lit", bus.rsp_data, lit[n]);
      if (n == 0) chk("burst_busy", bus.busy, 32'd1);
    end
    at_cyc(t + 19);
    chk("burst_end_valid", bus.rsp_valid, 32'd0);
    wait_idle(c);
    chk("burst_idle_cyc", c, t + 20);

    // wrap-around burst
    do_req(1'b0, 5'd14, 4'd3, 24'h0, t);
    for (int n = 0; n < 4; n++) begin
      at_cyc(t + 1 + n);
      chk("wrap_addr", bus.mem_addr, wrap_a[n]);
      chk("wrap_we", bus.mem_we, 32'd0);
    end
    wait_idle(c);

    // address masking on write and read
    do_req(1'b1, 5'b10010, 4'd0, 24'h111111, t);
    at_cyc(t + 1);
    chk("mask_we_hi", bus.mem_we, 32'd1);
    chk("mask_addr", bus.mem_addr, 32'd2);
    chk("mask_wdata", bus.mem_wdata, 24'h111111);
    chk("mask_no_rsp", bus.rsp_valid, 32'd0);
    at_cyc(t + 2);
    chk("mask_we_lo", bus.mem_we, 32'd0);
    step();
    do_req(1'b0, 5'b10010, 4'd0, 24'h0, t);
    wait_rsp(c, d, l);
    chk("mask_rd_data", d, 24'h111111);
    wait_idle(c);

    // back-pressure: consumer stalled 20 cycles, then toggling
    bus.rsp_ready = 1'b0;
    do_req(1'b0, 5'd0, 4'd15, 24'h0, t);
    for (int n = 3; n <= 20; n++) begin
      at_cyc(t + n);
      chk("bp_valid", bus.rsp_valid, 32'd1);
      chk("bp_hold", bus.rsp_data, 24'h008000);
    end
    chk("bp_issue_count", bus.mem_addr, 32'd3);
    base = pop_cnt;
    for (int i = 0; i < 200; i++) begin
      step();
      bus.rsp_ready = ~bus.rsp_ready;
      if (pop_cnt - base >= 16) break;
    end
    chk("bp_beats", pop_cnt - base, 32'd16);
    chk("bp_queue_empty", exp_q.size(), 32'd0);
    bus.rsp_ready = 1'b1;
    wait_idle(c);

    // reset during beat 5 of a 16-beat read
    do_req(1'b0, 5'd0, 4'd15, 24'h0, t);
    while (cyc < t + 7) step();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", bus.req_ready, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_valid", bus.rsp_valid, 32'd0);
    chk("after_rst_busy", bus.busy, 32'd0);
    chk("after_rst_ready", bus.req_ready, 32'd1);
    step();
    do_req(1'b0, 5'd3, 4'd0, 24'h0, t);
    wait_rsp(c, d, l);
    chk("fresh_cyc", c, t + 3);
    chk("fresh_data", d, 24'h654321);
    chk("fresh_last", l, 32'd1);
    wait_idle(c);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
